// File: rtl/dbgnoc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbgnoc_pkg
// Purpose  : Shared definitions for the debug-NoC output arbiter: flit type
//            codes, flit width helper and the arbiter FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dbgnoc_pkg;

    // Flit type codes, carried in the top bits of every flit.
    localparam logic [1:0] c_flit_payload = 2'b00;
    localparam logic [1:0] c_flit_header  = 2'b01;
    localparam logic [1:0] c_flit_last    = 2'b10;
    localparam logic [1:0] c_flit_single  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    function automatic int flit_width(input int data_width, input int type_width);
        return data_width + type_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbgnoc_vc_out_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : dbgnoc_vc_out_arb_if
// Purpose  : Flit handshake bundle between the flit sources, the output
//            arbiter and the debug-NoC router port.
// Ports    : in_flit/in_valid/in_ready  - per-source flit inputs
//            out_flit/out_valid/out_ready - per-vchannel output port
//            master modport : arbiter side, slave modport : environment side
// Revision : 1.0 - initial release
// ============================================================================
interface dbgnoc_vc_out_arb_if #(
    parameter int FLIT_WIDTH = 18,
    parameter int NUM_SRC    = 3,
    parameter int VCHANNELS  = 2
);
    logic [NUM_SRC*FLIT_WIDTH-1:0] in_flit;
    logic [NUM_SRC-1:0]            in_valid;
    logic [NUM_SRC-1:0]            in_ready;
    logic [FLIT_WIDTH-1:0]         out_flit;
    logic [VCHANNELS-1:0]          out_valid;
    logic [VCHANNELS-1:0]          out_ready;

    modport master (
        input  in_flit, in_valid, out_ready,
        output in_ready, out_flit, out_valid
    );

    modport slave (
        output in_flit, in_valid, out_ready,
        input  in_ready, out_flit, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/dbgnoc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : dbgnoc_rr_arb
// Purpose  : Combinational round-robin arbiter. Search starts at ptr+1 and
//            wraps, so the requester named by ptr has the lowest priority.
// Ports    : req         - request vector
//            ptr         - index of the previous winner
//            grant       - one-hot grant
//            grant_idx   - index of the granted requester
//            grant_valid - any request granted
// Revision : 1.0 - initial release
// ============================================================================
module dbgnoc_rr_arb #(
    parameter int NUM_REQ   = 3,
    parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  wire logic [NUM_REQ-1:0]   req,
    input  wire logic [IDX_WIDTH-1:0] ptr,
    output logic      [NUM_REQ-1:0]   grant,
    output logic      [IDX_WIDTH-1:0] grant_idx,
    output logic                      grant_valid
);

    // First pass covers indices above ptr, second pass wraps to 0..ptr.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[i] && (i > int'(ptr))) begin
                grant_valid = 1'b1;
                grant[i]    = 1'b1;
                grant_idx   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[i] && (i <= int'(ptr))) begin
                grant_valid = 1'b1;
                grant[i]    = 1'b1;
                grant_idx   = IDX_WIDTH'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbgnoc_vc_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : dbgnoc_vc_out_arb
// Purpose  : Merges NUM_SRC flit sources onto one multi-vchannel debug-NoC
//            output with packet-atomic round-robin arbitration and a
//            one-entry registered output stage.
// Ports    : clk        - clock
//            rst        - asynchronous active-low reset
//            bus        - flit handshake bundle (master modport)
//            err_orphan - pulse when a stray non-header flit is dropped
//            grant_src  - source last granted a header/single flit
// Revision : 1.0 - initial release
// ============================================================================
module dbgnoc_vc_out_arb
    import dbgnoc_pkg::*;
#(
    parameter int          FLIT_DATA_WIDTH = 16,
    parameter int          FLIT_TYPE_WIDTH = 2,
    parameter int          NUM_SRC         = 3,
    parameter int          VCHANNELS       = 2,
    parameter logic [15:0] SRC_VC          = {8{2'd0}}
) (
    input  wire logic           clk,
    input  wire logic           rst,
    dbgnoc_vc_out_arb_if.master bus,
    output logic                err_orphan,
    output logic [2:0]          grant_src
);

    localparam int FLIT_WIDTH = flit_width(FLIT_DATA_WIDTH, FLIT_TYPE_WIDTH);
    localparam int IDX_WIDTH  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int VC_WIDTH   = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

    // Reset asserts immediately but releases only after two clean clock edges.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Per-source flit decode
    logic [FLIT_WIDTH-1:0] w_src_flit [NUM_SRC];
    logic [VC_WIDTH-1:0]   w_src_vc   [NUM_SRC];
    logic [NUM_SRC-1:0]    w_is_hdr, w_is_last, w_start_req, w_orph_req;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [FLIT_TYPE_WIDTH-1:0] w_type;
        logic                       w_is_single, w_is_payload;
        assign w_src_flit[i]  = bus.in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        assign w_type         = w_src_flit[i][FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
        assign w_src_vc[i]    = SRC_VC[2*i +: VC_WIDTH];
        assign w_is_hdr[i]    = (w_type == FLIT_TYPE_WIDTH'(c_flit_header));
        assign w_is_last[i]   = (w_type == FLIT_TYPE_WIDTH'(c_flit_last));
        assign w_is_single    = (w_type == FLIT_TYPE_WIDTH'(c_flit_single));
        assign w_is_payload   = (w_type == FLIT_TYPE_WIDTH'(c_flit_payload));
        assign w_start_req[i] = bus.in_valid[i] && (w_is_hdr[i] || w_is_single);
        assign w_orph_req[i]  = bus.in_valid[i] && (w_is_payload || w_is_last[i]);
    end

    // State
    arb_state_t            r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_rr_ptr, r_lock_src;
    logic                  r_ofull;
    logic [FLIT_WIDTH-1:0] r_oflit;
    logic [VC_WIDTH-1:0]   r_ovc;
    logic [2:0]            r_grant_src;

    // Packet-start arbitration
    logic [NUM_SRC-1:0]   w_arb_grant;
    logic [IDX_WIDTH-1:0] w_arb_idx;
    logic                 w_arb_valid;

    dbgnoc_rr_arb #(
        .NUM_REQ   (NUM_SRC),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_arb (
        .req         (w_start_req),
        .ptr         (r_rr_ptr),
        .grant       (w_arb_grant),
        .grant_idx   (w_arb_idx),
        .grant_valid (w_arb_valid)
    );

    // Orphan pick: fixed priority, lowest index wins.
    logic [NUM_SRC-1:0]   w_orph_oh;
    logic [IDX_WIDTH-1:0] w_orph_idx;
    logic                 w_orph_valid;

    always_comb begin
        w_orph_oh    = '0;
        w_orph_idx   = '0;
        w_orph_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_orph_valid && w_orph_req[i]) begin
                w_orph_valid  = 1'b1;
                w_orph_oh[i]  = 1'b1;
                w_orph_idx    = IDX_WIDTH'(i);
            end
        end
    end

    // Source selection
    logic [IDX_WIDTH-1:0] w_sel;
    logic [NUM_SRC-1:0]   w_sel_oh;
    logic                 w_sel_valid, w_sel_orphan;

    always_comb begin
        w_sel        = '0;
        w_sel_oh     = '0;
        w_sel_valid  = 1'b0;
        w_sel_orphan = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_sel       = w_arb_idx;
                    w_sel_oh    = w_arb_grant;
                    w_sel_valid = 1'b1;
                end else if (w_orph_valid) begin
                    w_sel        = w_orph_idx;
                    w_sel_oh     = w_orph_oh;
                    w_sel_valid  = 1'b1;
                    w_sel_orphan = 1'b1;
                end
            end
            ST_LOCKED: begin
                // Only the lock owner may move, whatever flit type it presents.
                w_sel       = r_lock_src;
                w_sel_oh    = NUM_SRC'(1) << r_lock_src;
                w_sel_valid = bus.in_valid[r_lock_src];
            end
            default: ;
        endcase
    end

    logic w_can_load, w_xfer, w_load;

    assign w_can_load = !r_ofull || bus.out_ready[r_ovc];
    assign w_xfer     = w_sel_valid && w_can_load && w_rst_n;
    assign w_load     = w_xfer && !w_sel_orphan;

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_load && w_is_hdr[w_sel])  w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_load && w_is_last[w_sel]) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Output stage and arbitration bookkeeping
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ofull     <= 1'b0;
            r_oflit     <= '0;
            r_ovc       <= '0;
            r_rr_ptr    <= IDX_WIDTH'(NUM_SRC - 1);
            r_lock_src  <= '0;
            r_grant_src <= '0;
        end else begin
            if (w_load) begin
                r_ofull <= 1'b1;
                r_oflit <= w_src_flit[w_sel];
                r_ovc   <= w_src_vc[w_sel];
            end else if (r_ofull && bus.out_ready[r_ovc]) begin
                r_ofull <= 1'b0;
            end
            if (r_state == ST_IDLE && w_load) begin
                r_rr_ptr    <= w_sel;
                r_lock_src  <= w_sel;
                r_grant_src <= 3'(w_sel);
            end
        end
    end

    assign bus.in_ready  = w_xfer ? w_sel_oh : '0;
    assign bus.out_flit  = r_oflit;
    assign bus.out_valid = r_ofull ? (VCHANNELS'(1) << r_ovc) : '0;
    assign err_orphan    = w_xfer && w_sel_orphan;
    assign grant_src     = r_grant_src;

endmodule
`default_nettype wire

// File: tb/tb_dbgnoc_vc_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbgnoc_vc_out_arb
// Purpose  : Directed, table-driven self-checking bench for dbgnoc_vc_out_arb
//            (3 sources, 2 vchannels; sources 0 and 2 on vc1, source 1 on vc0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbgnoc_vc_out_arb;

    localparam logic [1:0] T_P = 2'b00;
    localparam logic [1:0] T_H = 2'b01;
    localparam logic [1:0] T_L = 2'b10;
    localparam logic [1:0] T_S = 2'b11;
    localparam logic [17:0] Z  = 18'h0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       err_orphan;
    logic [2:0] grant_src;

    int n_checks = 0;
    int n_fail   = 0;

    dbgnoc_vc_out_arb_if #(.FLIT_WIDTH(18), .NUM_SRC(3), .VCHANNELS(2)) bus ();

    dbgnoc_vc_out_arb #(
        .FLIT_DATA_WIDTH (16),
        .FLIT_TYPE_WIDTH (2),
        .NUM_SRC         (3),
        .VCHANNELS       (2),
        .SRC_VC          (16'h0011)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_orphan (err_orphan),
        .grant_src  (grant_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  in_valid;
        logic [17:0] f0;
        logic [17:0] f1;
        logic [17:0] f2;
        logic [1:0]  out_ready;
        logic [2:0]  exp_in_ready;
        logic        exp_err;
        logic [1:0]  exp_out_valid;
        logic [17:0] exp_out_flit;
        logic [2:0]  exp_grant;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [17:0] fl(input logic [1:0] t, input logic [15:0] d);
        return {t, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [17:0] f0, input logic [17:0] f1,
                         input logic [17:0] f2, input logic [1:0] ordy);
        bus.in_valid  = v;
        bus.in_flit   = {f2, f1, f0};
        bus.out_ready = ordy;
    endtask

    // Inputs change 2 time units after the rising edge; checks happen 1 later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arbitration, locking, bubbles and orphans (out_ready held high).
        vecs[0]  = '{3'b101, fl(T_H,16'hA000), Z, fl(T_H,16'hC000), 2'b11, 3'b001, 1'b0, 2'b00, 18'h00000, 3'd0};
        vecs[1]  = '{3'b101, fl(T_P,16'hA001), Z, fl(T_H,16'hC000), 2'b11, 3'b001, 1'b0, 2'b10, 18'h1A000, 3'd0};
        vecs[2]  = '{3'b101, fl(T_L,16'hA002), Z, fl(T_H,16'hC000), 2'b11, 3'b001, 1'b0, 2'b10, 18'h0A001, 3'd0};
        vecs[3]  = '{3'b100, Z, Z, fl(T_H,16'hC000),                2'b11, 3'b100, 1'b0, 2'b10, 18'h2A002, 3'd0};
        vecs[4]  = '{3'b101, fl(T_S,16'hA100), Z, fl(T_L,16'hC001), 2'b11, 3'b100, 1'b0, 2'b10, 18'h1C000, 3'd2};
        vecs[5]  = '{3'b001, fl(T_S,16'hA100), Z, Z,                2'b11, 3'b001, 1'b0, 2'b10, 18'h2C001, 3'd2};
        vecs[6]  = '{3'b010, Z, fl(T_H,16'hB000), Z,                2'b11, 3'b010, 1'b0, 2'b10, 18'h3A100, 3'd0};
        vecs[7]  = '{3'b011, fl(T_S,16'hA200), fl(T_P,16'hB001), Z, 2'b11, 3'b010, 1'b0, 2'b01, 18'h1B000, 3'd1};
        vecs[8]  = '{3'b001, fl(T_S,16'hA200), Z, Z,                2'b11, 3'b000, 1'b0, 2'b01, 18'h0B001, 3'd1};
        vecs[9]  = '{3'b011, fl(T_S,16'hA200), fl(T_L,16'hB002), Z, 2'b11, 3'b010, 1'b0, 2'b00, 18'h0B001, 3'd1};
        vecs[10] = '{3'b001, fl(T_S,16'hA200), Z, Z,                2'b11, 3'b001, 1'b0, 2'b01, 18'h2B002, 3'd1};
        vecs[11] = '{3'b000, Z, Z, Z,                               2'b11, 3'b000, 1'b0, 2'b10, 18'h3A200, 3'd0};
        vecs[12] = '{3'b010, Z, fl(T_P,16'hBEEF), Z,                2'b11, 3'b010, 1'b1, 2'b00, 18'h3A200, 3'd0};
        vecs[13] = '{3'b000, Z, Z, Z,                               2'b11, 3'b000, 1'b0, 2'b00, 18'h3A200, 3'd0};
        vecs[14] = '{3'b101, fl(T_L,16'hA300), Z, fl(T_H,16'hC100), 2'b11, 3'b100, 1'b0, 2'b00, 18'h3A200, 3'd0};
        vecs[15] = '{3'b101, fl(T_L,16'hA300), Z, fl(T_L,16'hC101), 2'b11, 3'b100, 1'b0, 2'b10, 18'h1C100, 3'd2};
        vecs[16] = '{3'b001, fl(T_L,16'hA300), Z, Z,                2'b11, 3'b001, 1'b1, 2'b10, 18'h2C101, 3'd2};
        vecs[17] = '{3'b000, Z, Z, Z,                               2'b11, 3'b000, 1'b0, 2'b00, 18'h2C101, 3'd2};

        // Reset with a header offered: nothing may be accepted.
        drive(3'b001, fl(T_H,16'h5555), Z, Z, 2'b11);
        repeat (3) @(posedge clk);
        #3;
        check("reset in_ready",   bus.in_ready,  3'b000);
        check("reset out_valid",  bus.out_valid, 2'b00);
        check("reset out_flit",   bus.out_flit,  18'h0);
        check("reset err_orphan", err_orphan,    1'b0);
        check("reset grant_src",  grant_src,     3'd0);
        drive(3'b000, Z, Z, Z, 2'b11);
        next_cycle();
        rst = 1'b1;
        repeat (3) next_cycle();

        for (int r = 0; r < 18; r++) begin
            drive(vecs[r].in_valid, vecs[r].f0, vecs[r].f1, vecs[r].f2, vecs[r].out_ready);
            #1;
            check($sformatf("row%0d in_ready", r),   bus.in_ready,  vecs[r].exp_in_ready);
            check($sformatf("row%0d err_orphan", r), err_orphan,    vecs[r].exp_err);
            check($sformatf("row%0d out_valid", r),  bus.out_valid, vecs[r].exp_out_valid);
            check($sformatf("row%0d out_flit", r),   bus.out_flit,  vecs[r].exp_out_flit);
            check($sformatf("row%0d grant_src", r),  grant_src,     vecs[r].exp_grant);
            next_cycle();
        end

        // Back-to-back SINGLE flits from source 0 (vc1) at full throughput.
        for (int k = 0; k < 8; k++) begin
            drive(3'b001, fl(T_S, 16'h1234 + 16'(k)), Z, Z, 2'b10);
            #1;
            check($sformatf("b2b%0d in_ready", k), bus.in_ready, 3'b001);
            if (k == 0) begin
                check("b2b0 out_valid", bus.out_valid, 2'b00);
            end else begin
                check($sformatf("b2b%0d out_valid", k), bus.out_valid, 2'b10);
                check($sformatf("b2b%0d out_flit", k),  bus.out_flit,  fl(T_S, 16'h1234 + 16'(k - 1)));
            end
            next_cycle();
        end
        drive(3'b000, Z, Z, Z, 2'b10);
        #1;
        check("b2b last out_flit",  bus.out_flit,  18'h3123B);
        check("b2b last out_valid", bus.out_valid, 2'b10);
        next_cycle();
        #1;
        check("b2b drained out_valid", bus.out_valid, 2'b00);

        // Output stall: held flit stays put, nothing accepted; release drains
        // and reloads in the same cycle.
        drive(3'b001, fl(T_S,16'hD000), Z, Z, 2'b00);
        #1;
        check("stall load in_ready", bus.in_ready, 3'b001);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(3'b101, fl(T_S,16'hD001), Z, fl(T_S,16'hE201), 2'b00);
            #1;
            check($sformatf("stall%0d in_ready", k),  bus.in_ready,  3'b000);
            check($sformatf("stall%0d out_flit", k),  bus.out_flit,  18'h3D000);
            check($sformatf("stall%0d out_valid", k), bus.out_valid, 2'b10);
            next_cycle();
        end
        drive(3'b101, fl(T_S,16'hD001), Z, fl(T_S,16'hE201), 2'b10);
        #1;
        check("release in_ready", bus.in_ready, 3'b100);
        next_cycle();
        drive(3'b000, Z, Z, Z, 2'b10);
        #1;
        check("reload out_valid", bus.out_valid, 2'b10);
        check("reload out_flit",  bus.out_flit,  18'h3E201);
        check("reload grant_src", grant_src,     3'd2);
        next_cycle();
        #1;
        check("reload drained out_valid", bus.out_valid, 2'b00);

        // Reset in the middle of a stalled packet from source 1.
        drive(3'b010, Z, fl(T_H,16'hB500), Z, 2'b00);
        #1;
        check("mid hdr in_ready", bus.in_ready, 3'b010);
        next_cycle();
        drive(3'b010, Z, fl(T_P,16'hB501), Z, 2'b00);
        #1;
        check("mid held out_valid", bus.out_valid, 2'b01);
        check("mid held in_ready",  bus.in_ready,  3'b000);
        rst = 1'b0;
        #1;
        check("async rst out_valid", bus.out_valid, 2'b00);
        check("async rst out_flit",  bus.out_flit,  18'h0);
        check("async rst in_ready",  bus.in_ready,  3'b000);
        check("async rst grant_src", grant_src,     3'd0);
        drive(3'b000, Z, Z, Z, 2'b11);
        repeat (2) next_cycle();
        rst = 1'b1;
        repeat (3) next_cycle();
        drive(3'b111, fl(T_S,16'hA555), fl(T_P,16'hB501), fl(T_S,16'hC555), 2'b11);
        #1;
        check("post rst in_ready",   bus.in_ready, 3'b001);
        check("post rst err_orphan", err_orphan,   1'b0);
        next_cycle();
        drive(3'b000, Z, Z, Z, 2'b11);
        #1;
        check("post rst out_valid", bus.out_valid, 2'b10);
        check("post rst out_flit",  bus.out_flit,  18'h3A555);
        check("post rst grant_src", grant_src,     3'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbgnoc_vc_out_arb.md
Name: dbgnoc_vc_out_arb

Overview:
Parametrised successor to the fixed two-source debug-NoC output mux in the network adapter. Merges NUM_SRC flit sources onto one debug-NoC output port carrying VCHANNELS virtual channels, with packet-atomic round-robin arbitration. A one-entry registered output stage gives full-throughput, 1-cycle-latency handoff. Sits between the adapter's conf/DMA/NA-output producers and the debug-NoC router port.

Parameters:
FLIT_DATA_WIDTH, 16, flit payload bits
FLIT_TYPE_WIDTH, 2, flit type bits (MSBs of flit)
NUM_SRC, 3, number of flit sources (1..8)
VCHANNELS, 2, number of output virtual channels (1..4)
SRC_VC, {8{2'd0}}, packed 2-bit vchannel index per source, source i at bits [2i+1:2i]

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_flit  in  NUM_SRC*FLIT_WIDTH  source flits; source i at [i*FLIT_WIDTH +: FLIT_WIDTH]; FLIT_WIDTH = FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH
in_valid  in  NUM_SRC  per-source flit valid
in_ready  out  NUM_SRC  per-source accept
out_flit  out  FLIT_WIDTH  registered output flit
out_valid  out  VCHANNELS  one-hot valid on SRC_VC of the owning source
out_ready  in  VCHANNELS  per-vchannel downstream ready
err_orphan  out  1  1-cycle pulse: non-header flit dropped in IDLE
grant_src  out  3  index of the source last granted a header (debug)

Behaviour:
- Flit types (top FLIT_TYPE_WIDTH bits): PAYLOAD=2'b00, HEADER=2'b01, LAST=2'b10, SINGLE=2'b11.
- Transfer on a source when in_valid[i] && in_ready[i]. Transfer on the output when out_valid[v] && out_ready[v].
- Output stage: register ofull, oflit, ovc.
  - can_load = !ofull || out_ready[ovc].
  - out_valid = ofull ? (1 << ovc) : 0.
  - Latency: an accepted input flit appears on out_flit the next cycle.
  - Back-to-back flits are sustained when out_ready is held high.
- in_ready[i] = can_load && (i == sel) && sel_valid. All other sources see 0. Combinational, no dependency on in_valid[i] beyond selection.
- FSM IDLE / LOCKED:
  - IDLE: candidates are sources with in_valid and type HEADER or SINGLE. Round-robin search starts at rr_ptr+1 mod NUM_SRC.
  - On transfer: rr_ptr <= sel and grant_src <= sel. HEADER -> LOCKED with lock_src=sel; SINGLE -> stay IDLE.
  - LOCKED: only lock_src is eligible, whatever its flit type. Transfer of LAST -> IDLE. A HEADER or SINGLE seen while LOCKED is forwarded unchanged and does not unlock.
  - Other sources wait while LOCKED, even if their vchannel is ready (no interleaving).
- Orphan: in IDLE with no header candidate, the lowest-index source presenting PAYLOAD/LAST gets in_ready = 1. That flit is consumed without loading the output and err_orphan pulses. Orphans are never taken while a header candidate exists.
- Simultaneous: output drain and new load in the same cycle is legal (ofull stays 1). A load with can_load=0 never happens.
- Reset (async assert, sync-released deassert inside block):
  - Outputs: out_valid=0, out_flit=0, err_orphan=0, grant_src=0, in_ready=0.
  - State: FSM=IDLE, rr_ptr=NUM_SRC-1 (source 0 has first priority).
  - Reset mid-packet discards the held flit and lock. The downstream sees a truncated packet; recovery is the system's responsibility.
- NUM_SRC=1: arbitration degenerates; locking and orphan checks remain.

Decomposition:
- Package dbgnoc_pkg: flit type constants (PAYLOAD/HEADER/LAST/SINGLE), FLIT_WIDTH function, FSM state encoding.
- One sub-module: dbgnoc_rr_arb. NUM_SRC-wide round-robin arbiter with req, ptr, grant one-hot and grant index outputs. Reused by the DMA input side.

Test Plan:
- Single source, SINGLE flit 18'h3_1234, SRC_VC=1, out_ready=2'b10 -> next cycle out_valid=2'b10, out_flit=18'h3_1234; in_ready high every cycle for 8 back-to-back flits.
- Src0 and src2 both offer HEADER in the same cycle after reset -> src0 granted. Its 3-flit packet (HEADER, PAYLOAD, LAST) exits contiguously. Then src2 is granted, grant_src=2.
- Src1 mid-packet (LOCKED) while src0 offers SINGLE -> src0 in_ready=0 until src1's LAST transfers; src0's flit appears the cycle after.
- out_ready[ovc]=0 for 5 cycles with ofull=1 -> out_flit stable, all in_ready=0. On release, one flit drains and a new one loads in the same cycle.
- IDLE, src1 presents PAYLOAD 18'h0_BEEF, no headers -> in_ready[1]=1, err_orphan=1 for one cycle, out_valid stays 0.
- Assert rst while LOCKED with ofull=1 -> out_valid=0 asynchronously. After release, source 0 has priority and no lock remains.
